word_to_block_packer: RTL and testbench

//  Upstream stage of the 128->32 output shift register, mirrored for the input side.

---
 rtl/word_to_block_packer.sv | 79 +++++++
 tb/tb_word_to_block_packer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/word_to_block_packer.sv
// Packs four WORD_W-bit words (first word in the MSBs) into one BLOCK_W-bit block,
// with a single-entry output slot handed off through a valid/ready handshake.
module word_to_block_packer #(
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned BLOCK_W = 128
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic [WORD_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         word_cnt
);

    localparam int unsigned NWORDS = BLOCK_W / WORD_W;
    localparam int unsigned ASM_W  = BLOCK_W - WORD_W;
    localparam logic [1:0]  LAST   = 2'(NWORDS - 1);

    logic [ASM_W-1:0]   asm_q, asm_d;
    logic [1:0]         word_cnt_q, word_cnt_d;
    logic [BLOCK_W-1:0] out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               in_acc, out_acc;

    // The final word is held off only while the slot is full and not draining.
    assign in_ready = (word_cnt_q != LAST) | ~out_valid_q | out_ready;
    assign in_acc   = in_valid & in_ready;
    assign out_acc  = out_valid_q & out_ready;

    always_comb begin
        asm_d       = asm_q;
        word_cnt_d  = word_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (clear) begin
            word_cnt_d  = '0;
            out_valid_d = 1'b0;
        end else begin
            if (out_acc)
                out_valid_d = 1'b0;
            if (in_acc) begin
                if (word_cnt_q == LAST) begin
                    out_data_d  = {asm_q, in_data};
                    out_valid_d = 1'b1;
                    word_cnt_d  = '0;
                end else begin
                    for (int unsigned k = 0; k < NWORDS - 1; k++) begin
                        if (word_cnt_q == 2'(k))
                            asm_d[ASM_W-1-k*WORD_W -: WORD_W] = in_data;
                    end
                    word_cnt_d = word_cnt_q + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            asm_q       <= '0;
            word_cnt_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            asm_q       <= asm_d;
            word_cnt_q  <= word_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_word_to_block_packer.sv
// Directed bench for word_to_block_packer: table-driven vectors plus async-reset
// and streaming sequences.
module tb_word_to_block_packer;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         clear = 1'b0;
    logic [31:0]  in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [1:0]   word_cnt;

    int checks = 0;
    int errors = 0;

    word_to_block_packer #(.WORD_W(32), .BLOCK_W(128)) dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .word_cnt (word_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         iv;
        logic [31:0]  d;
        logic         ordy;
        logic         clr;
        logic         e_ir;
        logic [1:0]   e_cnt;
        logic         e_ov;
        logic         chk_d;
        logic [127:0] e_d;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic iv, logic [31:0] d, logic ordy, logic clr,
                                logic e_ir, logic [1:0] e_cnt, logic e_ov,
                                logic chk_d, logic [127:0] e_d);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.clr = clr;
        v.e_ir = e_ir; v.e_cnt = e_cnt; v.e_ov = e_ov; v.chk_d = chk_d; v.e_d = e_d;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] d, input logic ordy, input logic clr);
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        clear     = clr;
    endtask

    localparam logic [127:0] BLK1 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] BLKG = 128'h00000001000000020000000300000004;
    localparam logic [127:0] BLKA = 128'hAAAA0000AAAA0001AAAA0002AAAA0003;
    localparam logic [127:0] BLKB = 128'hBBBB0000BBBB0001BBBB0002BBBB0003;
    localparam logic [127:0] BLKD = 128'hD0000000D0000001D0000002D0000003;

    initial begin
        logic [127:0] exp_blk;
        logic [31:0]  w;
        int           blocks;

        // basic four-word block, one-cycle out_valid pulse
        vecs.push_back(mk(1, 32'h01234567, 1, 0, 1, 1, 0, 0, '0));
        vecs.push_back(mk(1, 32'h89ABCDEF, 1, 0, 1, 2, 0, 0, '0));
        vecs.push_back(mk(1, 32'h01234567, 1, 0, 1, 3, 0, 0, '0));
        vecs.push_back(mk(1, 32'h89ABCDEF, 1, 0, 1, 0, 1, 1, BLK1));
        vecs.push_back(mk(0, 32'h0,        1, 0, 1, 0, 0, 1, BLK1));
        vecs.push_back(mk(0, 32'h0,        1, 0, 1, 0, 0, 0, '0));
        // gaps between words
        vecs.push_back(mk(1, 32'h00000001, 1, 0, 1, 1, 0, 0, '0));
        vecs.push_back(mk(0, 32'hFFFFFFFF, 1, 0, 1, 1, 0, 0, '0));
        vecs.push_back(mk(1, 32'h00000002, 1, 0, 1, 2, 0, 0, '0));
        vecs.push_back(mk(0, 32'hFFFFFFFF, 1, 0, 1, 2, 0, 0, '0));
        vecs.push_back(mk(1, 32'h00000003, 1, 0, 1, 3, 0, 0, '0));
        vecs.push_back(mk(0, 32'hFFFFFFFF, 1, 0, 1, 3, 0, 0, '0));
        vecs.push_back(mk(1, 32'h00000004, 1, 0, 1, 0, 1, 1, BLKG));
        vecs.push_back(mk(0, 32'h0,        1, 0, 1, 0, 0, 1, BLKG));
        // stall: A pending, B3 blocked until out_ready
        vecs.push_back(mk(1, 32'hAAAA0000, 0, 0, 1, 1, 0, 0, '0));
        vecs.push_back(mk(1, 32'hAAAA0001, 0, 0, 1, 2, 0, 0, '0));
        vecs.push_back(mk(1, 32'hAAAA0002, 0, 0, 1, 3, 0, 0, '0));
        vecs.push_back(mk(1, 32'hAAAA0003, 0, 0, 1, 0, 1, 1, BLKA));
        vecs.push_back(mk(1, 32'hBBBB0000, 0, 0, 1, 1, 1, 1, BLKA));
        vecs.push_back(mk(1, 32'hBBBB0001, 0, 0, 1, 2, 1, 1, BLKA));
        vecs.push_back(mk(1, 32'hBBBB0002, 0, 0, 1, 3, 1, 1, BLKA));
        vecs.push_back(mk(1, 32'hBBBB0003, 0, 0, 0, 3, 1, 1, BLKA));
        vecs.push_back(mk(1, 32'hBBBB0003, 0, 0, 0, 3, 1, 1, BLKA));
        vecs.push_back(mk(1, 32'hBBBB0003, 1, 0, 1, 0, 1, 1, BLKB));
        vecs.push_back(mk(0, 32'h0,        0, 0, 1, 0, 1, 1, BLKB));
        vecs.push_back(mk(0, 32'h0,        1, 0, 1, 0, 0, 1, BLKB));
        // clear drops the partial block and the word presented with it
        vecs.push_back(mk(1, 32'hC0000000, 1, 0, 1, 1, 0, 0, '0));
        vecs.push_back(mk(1, 32'hC0000001, 1, 0, 1, 2, 0, 0, '0));
        vecs.push_back(mk(1, 32'hDEADBEEF, 1, 1, 1, 0, 0, 0, '0));
        vecs.push_back(mk(1, 32'hD0000000, 1, 0, 1, 1, 0, 0, '0));
        vecs.push_back(mk(1, 32'hD0000001, 1, 0, 1, 2, 0, 0, '0));
        vecs.push_back(mk(1, 32'hD0000002, 1, 0, 1, 3, 0, 0, '0));
        vecs.push_back(mk(1, 32'hD0000003, 0, 0, 1, 0, 1, 1, BLKD));
        vecs.push_back(mk(0, 32'h0,        0, 1, 1, 0, 0, 0, '0));

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_word_cnt",  {126'b0, word_cnt}, 128'd0);
        check("rst_out_valid", {127'b0, out_valid}, 128'd0);
        check("rst_out_data",  out_data, 128'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_in_ready",  {127'b0, in_ready}, 128'd1);

        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].clr);
            #1;
            check($sformatf("v%0d_in_ready", i), {127'b0, in_ready}, {127'b0, vecs[i].e_ir});
            @(posedge clk);
            #1;
            check($sformatf("v%0d_word_cnt", i), {126'b0, word_cnt}, {126'b0, vecs[i].e_cnt});
            check($sformatf("v%0d_out_valid", i), {127'b0, out_valid}, {127'b0, vecs[i].e_ov});
            if (vecs[i].chk_d)
                check($sformatf("v%0d_out_data", i), out_data, vecs[i].e_d);
        end

        // async reset mid-cycle with word_cnt=2 and a pending block
        for (int i = 0; i < 6; i++)
            drive(1, 32'hE0000000 + 32'(i), 0, 0);
        drive(0, 32'h0, 0, 0);
        #1;
        check("pre_rst_word_cnt",  {126'b0, word_cnt}, 128'd2);
        check("pre_rst_out_valid", {127'b0, out_valid}, 128'd1);
        check("pre_rst_out_data",  out_data, 128'hE0000000E0000001E0000002E0000003);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("arst_word_cnt",  {126'b0, word_cnt}, 128'd0);
        check("arst_out_valid", {127'b0, out_valid}, 128'd0);
        check("arst_out_data",  out_data, 128'd0);
        check("arst_in_ready",  {127'b0, in_ready}, 128'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("post_rst_in_ready", {127'b0, in_ready}, 128'd1);

        // streaming: 32 words back to back
        blocks  = 0;
        exp_blk = '0;
        for (int i = 0; i < 32; i++) begin
            w = 32'h10000000 + 32'(i);
            exp_blk = {exp_blk[95:0], w};
            drive(1, w, 1, 0);
            #1;
            check($sformatf("s%0d_in_ready", i), {127'b0, in_ready}, 128'd1);
            @(posedge clk);
            #1;
            if ((i % 4) == 3) begin
                check($sformatf("s%0d_out_valid", i), {127'b0, out_valid}, 128'd1);
                check($sformatf("s%0d_out_data", i), out_data, exp_blk);
                if (out_valid) blocks++;
            end else begin
                check($sformatf("s%0d_out_valid", i), {127'b0, out_valid}, 128'd0);
            end
        end
        drive(0, 32'h0, 1, 0);
        @(posedge clk);
        #1;
        check("stream_tail_out_valid", {127'b0, out_valid}, 128'd0);
        check("stream_blocks", 128'(blocks), 128'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
